// File: rtl/answer_entry_pkg.sv
// Shared types and constants for the player-1 answer entry stage.
// Includes the digit increment helper that wraps at a configurable maximum.
package answer_entry_pkg;

  typedef enum logic {
    ST_EDIT = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;

  localparam logic [1:0] CUR_LAST = 2'd2;

  // Anything at or above max_d wraps to zero, so a stray out-of-range value self-heals.
  function automatic logic [DIGIT_W-1:0] wrap_inc(input logic [DIGIT_W-1:0] d,
                                                  input logic [DIGIT_W-1:0] max_d);
    return (d >= max_d) ? '0 : d + DIGIT_W'(1);
  endfunction

endpackage

// File: rtl/answer_entry_if.sv
// Button inputs, game-control clear and answer/display outputs of the entry stage.
// master = driver of buttons and consumer of answers, slave = the entry stage itself.
interface answer_entry_if;
  import answer_entry_pkg::*;

  logic                          BTN_UP;
  logic                          BTN_NEXT;
  logic                          BTN_ENTER;
  logic                          CLEAR;
  logic [DIGIT_W-1:0]            ANSWER_1;
  logic [DIGIT_W-1:0]            ANSWER_2;
  logic [DIGIT_W-1:0]            ANSWER_3;
  logic [NUM_DIGITS*DIGIT_W-1:0] EDIT_DIGS;
  logic [1:0]                    CURSOR;
  logic                          BUSY;

  modport master (
    output BTN_UP, BTN_NEXT, BTN_ENTER, CLEAR,
    input  ANSWER_1, ANSWER_2, ANSWER_3, EDIT_DIGS, CURSOR, BUSY
  );

  modport slave (
    input  BTN_UP, BTN_NEXT, BTN_ENTER, CLEAR,
    output ANSWER_1, ANSWER_2, ANSWER_3, EDIT_DIGS, CURSOR, BUSY
  );

endinterface

// File: rtl/answer_entry_btn_conditioner.sv
// Raw push-button conditioning: 2-FF synchronizer, counter debounce and a one-cycle
// registered pulse on each accepted press. Releases produce no pulse.
module btn_conditioner #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic RAW,
  output logic LEVEL,
  output logic PRESS
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic        r_press;
  logic [19:0] r_cnt;
  logic        w_settled;

  assign w_settled = (r_cnt == DEB_CYCLES - 20'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= RAW;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any cycle agreeing with the current level restarts the stability count.
      if (r_sync2 != r_level) begin
        if (w_settled) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= r_sync2;
        end else begin
          r_cnt <= r_cnt + 20'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign LEVEL = r_level;
  assign PRESS = r_press;

endmodule

// File: rtl/answer_entry.sv
// Player-1 answer entry: edits three digits with UP/NEXT, publishes them on a valid
// ENTER for a fixed hold window, and lets game control wipe everything with CLEAR.
module answer_entry
  import answer_entry_pkg::*;
#(
  parameter logic [19:0]        DEB_CYCLES  = 20'd500000,
  parameter logic [23:0]        HOLD_CYCLES = 24'd5000000,
  parameter logic [DIGIT_W-1:0] MAX_DIGIT   = 4'd9
) (
  input logic           CLK,
  input logic           RST,
  answer_entry_if.slave bus
);

  logic                                w_up;
  logic                                w_next;
  logic                                w_enter;
  logic [2:0]                          w_unused_lvl;
  logic                                w_all_nz;

  state_t                              r_state;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  r_dig;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  r_ans;
  logic [1:0]                          r_cursor;
  logic [23:0]                         r_hold;
  logic                                r_busy;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .CLK(CLK), .RST(RST), .RAW(bus.BTN_UP),    .LEVEL(w_unused_lvl[0]), .PRESS(w_up)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_next (
    .CLK(CLK), .RST(RST), .RAW(bus.BTN_NEXT),  .LEVEL(w_unused_lvl[1]), .PRESS(w_next)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
    .CLK(CLK), .RST(RST), .RAW(bus.BTN_ENTER), .LEVEL(w_unused_lvl[2]), .PRESS(w_enter)
  );

  // A zero digit means "no factor", so a submit needs all three filled in.
  assign w_all_nz = (r_dig[0] != '0) && (r_dig[1] != '0) && (r_dig[2] != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_EDIT;
      r_dig    <= '0;
      r_ans    <= '0;
      r_cursor <= '0;
      r_hold   <= '0;
      r_busy   <= 1'b0;
    end else if (bus.CLEAR) begin
      r_state  <= ST_EDIT;
      r_dig    <= '0;
      r_ans    <= '0;
      r_cursor <= '0;
      r_hold   <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_EDIT: begin
          // An ENTER pulse consumes the cycle even when rejected.
          if (w_enter) begin
            if (w_all_nz) begin
              r_ans   <= r_dig;
              r_busy  <= 1'b1;
              r_hold  <= HOLD_CYCLES - 24'd1;
              r_state <= ST_HOLD;
            end
          end else if (w_next) begin
            r_cursor <= (r_cursor >= CUR_LAST) ? 2'd0 : r_cursor + 2'd1;
          end else if (w_up) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (r_cursor == 2'(i)) r_dig[i] <= wrap_inc(r_dig[i], MAX_DIGIT);
            end
          end
        end
        ST_HOLD: begin
          if (r_hold == '0) begin
            r_state  <= ST_EDIT;
            r_dig    <= '0;
            r_ans    <= '0;
            r_cursor <= '0;
            r_busy   <= 1'b0;
          end else begin
            r_hold <= r_hold - 24'd1;
          end
        end
        default: r_state <= ST_EDIT;
      endcase
    end
  end

  assign bus.ANSWER_1  = r_ans[0];
  assign bus.ANSWER_2  = r_ans[1];
  assign bus.ANSWER_3  = r_ans[2];
  assign bus.EDIT_DIGS = r_dig;
  assign bus.CURSOR    = r_cursor;
  assign bus.BUSY      = r_busy;

endmodule

// File: tb/tb_answer_entry.sv
// Directed bench for answer_entry with short debounce/hold parameters.
module tb_answer_entry;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   up_press_cnt = 0;
  int   b0;
  int   p0;

  answer_entry_if bus ();

  answer_entry #(
    .DEB_CYCLES (20'd4),
    .HOLD_CYCLES(24'd8),
    .MAX_DIGIT  (4'd9)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.BUSY) busy_cnt <= busy_cnt + 1;
    if (dut.u_up.PRESS) up_press_cnt <= up_press_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] a3, input logic [11:0] ed, input logic [1:0] cur,
                         input logic busy);
    chk({tag, "_a1"},   32'(bus.ANSWER_1),  32'(a1));
    chk({tag, "_a2"},   32'(bus.ANSWER_2),  32'(a2));
    chk({tag, "_a3"},   32'(bus.ANSWER_3),  32'(a3));
    chk({tag, "_edit"}, 32'(bus.EDIT_DIGS), 32'(ed));
    chk({tag, "_cur"},  32'(bus.CURSOR),    32'(cur));
    chk({tag, "_busy"}, 32'(bus.BUSY),      32'(busy));
  endtask

  // Full press: held long enough to debounce, then released long enough to settle.
  task automatic press(input int which);
    case (which)
      0: bus.BTN_UP = 1'b1;
      1: bus.BTN_NEXT = 1'b1;
      default: bus.BTN_ENTER = 1'b1;
    endcase
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    bus.BTN_UP = 1'b0; bus.BTN_NEXT = 1'b0; bus.BTN_ENTER = 1'b0;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    bus.BTN_UP = 1'b0; bus.BTN_NEXT = 1'b0; bus.BTN_ENTER = 1'b0; bus.CLEAR = 1'b0;
    idle(2);
    chk_all("reset", 4'd0, 4'd0, 4'd0, 12'h000, 2'd0, 1'b0);
    RST = 1'b0;
    idle(2);

    // 1. Debounce: short hold, bounce, then a long hold
    p0 = up_press_cnt;
    bus.BTN_UP = 1'b1; idle(3); bus.BTN_UP = 1'b0; idle(10);
    chk("deb_short_edit", 32'(bus.EDIT_DIGS), 32'h000);
    bus.BTN_UP = 1'b1; idle(1); bus.BTN_UP = 1'b0; idle(1);
    bus.BTN_UP = 1'b1; idle(1); bus.BTN_UP = 1'b0; idle(10);
    chk("deb_bounce_edit", 32'(bus.EDIT_DIGS), 32'h000);
    chk("deb_no_press", 32'(up_press_cnt - p0), 32'd0);
    bus.BTN_UP = 1'b1; idle(10); bus.BTN_UP = 1'b0; idle(10);
    chk("deb_long_edit", 32'(bus.EDIT_DIGS), 32'h001);
    chk("deb_one_pulse", 32'(up_press_cnt - p0), 32'd1);

    // 2. Wrap: nine more UPs go 2..9 then back to 0; NEXT cycles 1,2,0
    for (int k = 1; k <= 9; k++) begin
      press(0);
      chk("wrap_digit", 32'(bus.EDIT_DIGS), 32'((k + 1) % 10));
    end
    press(1); chk("cursor_1", 32'(bus.CURSOR), 32'd1);
    press(1); chk("cursor_2", 32'(bus.CURSOR), 32'd2);
    press(1); chk("cursor_0", 32'(bus.CURSOR), 32'd0);

    // 3. Submit 2,3,5
    press(0); press(0);
    press(1); press(0); press(0); press(0);
    press(1); repeat (5) press(0);
    chk_all("pre_submit", 4'd0, 4'd0, 4'd0, 12'h532, 2'd2, 1'b0);
    b0 = busy_cnt;
    bus.BTN_ENTER = 1'b1;
    idle(7);
    chk_all("submit", 4'd2, 4'd3, 4'd5, 12'h532, 2'd2, 1'b1);
    bus.BTN_ENTER = 1'b0;
    idle(12);
    chk("busy_window", 32'(busy_cnt - b0), 32'd8);
    chk_all("after_hold", 4'd0, 4'd0, 4'd0, 12'h000, 2'd0, 1'b0);

    // 4. Rejected submit with a zero middle digit
    press(0); press(0); press(1); press(1);
    repeat (7) press(0);
    b0 = busy_cnt;
    press(2);
    chk_all("reject", 4'd0, 4'd0, 4'd0, 12'h702, 2'd2, 1'b0);
    chk("reject_busy", 32'(busy_cnt - b0), 32'd0);

    // 5. UP/NEXT ignored during HOLD, then CLEAR at hold cycle 3
    press(1); press(1); press(0);
    chk("pre_lock_edit", 32'(bus.EDIT_DIGS), 32'h712);
    bus.BTN_ENTER = 1'b1; idle(0);
    bus.BTN_UP = 1'b1;    idle(0);
    bus.BTN_NEXT = 1'b1;
    idle(7);
    chk_all("lockout", 4'd2, 4'd1, 4'd7, 12'h712, 2'd1, 1'b1);
    bus.CLEAR = 1'b1;
    idle(1);
    bus.CLEAR = 1'b0;
    chk_all("clear_hold", 4'd0, 4'd0, 4'd0, 12'h000, 2'd0, 1'b0);
    bus.BTN_UP = 1'b0; bus.BTN_NEXT = 1'b0; bus.BTN_ENTER = 1'b0;
    idle(12);
    chk_all("clear_settled", 4'd0, 4'd0, 4'd0, 12'h000, 2'd0, 1'b0);

    // 6. Async reset in HOLD, no clock edge between assert and check
    press(0); press(1); press(0); press(1); press(0);
    bus.BTN_ENTER = 1'b1;
    idle(7);
    chk_all("pre_reset", 4'd1, 4'd1, 4'd1, 12'h111, 2'd2, 1'b1);
    #1 RST = 1'b1; bus.BTN_ENTER = 1'b0;
    #2 chk_all("async_reset", 4'd0, 4'd0, 4'd0, 12'h000, 2'd0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    idle(2);

    // CLEAR and an accepted ENTER pulse in the same cycle
    press(0); press(1); press(0); press(1); press(0);
    bus.BTN_ENTER = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    bus.CLEAR = 1'b1;
    idle(1);
    bus.CLEAR = 1'b0;
    chk_all("clear_beats_enter", 4'd0, 4'd0, 4'd0, 12'h000, 2'd0, 1'b0);
    bus.BTN_ENTER = 1'b0;
    idle(12);
    chk("clear_enter_busy", 32'(bus.BUSY), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
